// File: rtl/snow64_fetch_queue_stage.sv
// Snow64 instruction-fetch front end.
// Issues sequential icache requests under a credit limit, queues the in-order
// responses together with their PC, and hands them to decode via valid/ready.
// An EX redirect flushes the queue, reloads the PC and marks every response
// still in flight as stale so it is dropped on arrival.
module snow64_fetch_queue_stage #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // icache request
    output logic                          req_valid,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic                          req_ready,
    // icache response, strictly in request order
    input  logic                          rsp_valid,
    input  logic [INSTR_WIDTH-1:0]        rsp_instr,
    // EX redirect
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    // decode side
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTR_WIDTH-1:0]        out_instr,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]  out_count
);

    localparam int INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int PW          = $clog2(QUEUE_DEPTH);
    localparam int CW          = PW + 1;
    localparam int XW          = CW + 1;

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));
    localparam logic [XW-1:0]         DEPTH_X    = XW'(QUEUE_DEPTH);
    localparam logic [CW-1:0]         DEPTH_C    = CW'(QUEUE_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t                mem [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         drop_cnt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [XW-1:0]         credit_used;
    logic                  fire;
    logic                  drop_hit;
    logic                  push;
    logic                  pop;

    // Queued entries plus outstanding requests may never exceed the depth, so
    // every response is guaranteed a slot. Held low during reset and redirect.
    assign credit_used      = {1'b0, count} + {1'b0, inflight};
    assign req_valid        = rst_n && !redirect_valid && (credit_used < DEPTH_X);
    assign req_addr         = fetch_pc;
    assign fire             = req_valid && req_ready;

    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // A response is consumed by the drop counter first; a redirect in the same
    // cycle also discards it because the queue is being flushed.
    assign drop_hit         = rsp_valid && (drop_cnt != '0);
    assign push             = rsp_valid && !drop_hit && !redirect_valid;
    assign pop              = out_valid && out_ready && !redirect_valid;

    assign out_valid        = (count != '0);
    assign out_count        = count;
    assign out_instr        = out_valid ? mem[rd_ptr].instr : '0;
    assign out_pc           = out_valid ? mem[rd_ptr].pc    : '0;

    // Fetch PC: sequential advance on each accepted request, reload on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
        end else if (fire) begin
            fetch_pc <= fetch_pc + STEP;
        end
    end

    // Outstanding-request counter and stale-response counter. On redirect,
    // everything still in flight (minus any response arriving now) is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            inflight <= inflight - CW'(rsp_valid);
            drop_cnt <= inflight - CW'(rsp_valid);
        end else begin
            inflight <= inflight + CW'(fire) - CW'(rsp_valid);
            if (drop_hit) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // PC tag for the next accepted response; tracks fetch_pc one response behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rsp_pc <= redirect_aligned;
        end else if (push) begin
            rsp_pc <= rsp_pc + STEP;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: out_valid gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: rsp_pc, instr: rsp_instr};
        end
    end

    // Credit bookkeeping sanity: counters stay within the queue depth and the
    // icache never answers a request that was not made.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= DEPTH_C);
    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
        inflight <= DEPTH_C);
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= inflight);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (inflight != '0));

endmodule
